and_gate_struct: RTL and testbench
==================================

AND_GATE_STRUCT -- requirements
Module: and_gate_struct

Interface
REQ-001 Parameter: CNT_W, default 8, width of the statistics counters (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all sequential logic samples on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: a  input  1  first AND operand.
REQ-005 Port: b  input  1  second AND operand.
REQ-006 Port: clr  input  1  synchronous clear of the statistics counters, active-high.
REQ-007 Port: y  output  1  combinational a AND b.
REQ-008 Port: y_q  output  1  y registered by one clk cycle.
REQ-009 Port: y_rise  output  1  one-cycle pulse on a 0->1 transition of y_q.
REQ-010 Port: hi_cnt  output  CNT_W  count of cycles with y_q = 1.
REQ-011 Port: rise_cnt  output  CNT_W  count of y_rise pulses.
REQ-012 Port: sat  output  1  sticky flag, set when either counter saturates.

Function
REQ-013 y SHALL equal a & b with zero latency and no clock dependency; truth table 00->0, 01->0, 10->0, 11->1.
REQ-014 y SHALL be built from one two-input AND gate primitive instance; no behavioural expression on the y path.
REQ-015 y SHALL remain fully combinational and valid while rst_n is low.
REQ-016 y_q SHALL take the value of y at each rising clk edge, giving one cycle of latency.
REQ-017 y_rise SHALL be 1 for exactly the cycle after y_q goes 0->1 (registered edge detect: y_q & ~y_q_prev, where y_q_prev is internal); it SHALL NOT pulse again while y_q stays 1.
REQ-018 hi_cnt SHALL increment by 1 on each rising edge where y_q = 1, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-019 rise_cnt SHALL increment by 1 on each rising edge where y_rise = 1, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-020 sat SHALL set on the edge at which either counter reaches its maximum value and SHALL hold until clr or reset.
REQ-021 clr = 1 SHALL zero hi_cnt, rise_cnt and sat on that edge, taking priority over a simultaneous increment.
REQ-022 clr SHALL NOT affect y, y_q or y_rise.
REQ-023 An X or Z on a or b SHALL propagate per gate-primitive semantics; no masking.

Reset
REQ-024 rst_n low SHALL immediately force y_q = 0, y_rise = 0, internal y_q_prev = 0, hi_cnt = 0, rise_cnt = 0 and sat = 0, independent of clk.
REQ-025 Reset SHALL abort any count in progress.
REQ-026 On the first rising edge after rst_n deasserts, y_q SHALL load y; if y = 1, y_rise SHALL pulse in the following cycle.

Configuration
REQ-027 Macro AND_GATE_STRUCT_STATS_EN: when defined, hi_cnt, rise_cnt and sat SHALL be implemented as specified in REQ-018 to REQ-021.
REQ-028 When AND_GATE_STRUCT_STATS_EN is undefined, hi_cnt, rise_cnt and sat SHALL be tied to constant 0, clr SHALL be ignored, and no counter flops SHALL be synthesized; y, y_q and y_rise are unchanged.

Verification
REQ-029 Truth table: apply a,b = 00, 01, 10, 11 at 10 ns intervals -> y = 0, 0, 0, 1 with no clock edge required; y_q follows one cycle later.
REQ-030 Edge detect: hold a = b = 1 for 5 cycles, then drop b -> exactly one y_rise pulse, rise_cnt = 1, hi_cnt = 5.
REQ-031 Saturation (CNT_W = 2, stats enabled): hold a = b = 1 for 6 cycles -> hi_cnt stops at 3, sat = 1 and stays 1.
REQ-032 Clear priority: assert clr in a cycle where y_q = 1 and hi_cnt = 2 -> hi_cnt = 0 and sat = 0 on that edge; counting resumes at 1 on the next edge.
REQ-033 Async reset: drop rst_n mid-cycle with y_q = 1 and hi_cnt = 4 -> y_q, y_rise and counters are 0 before the next clk edge, while y still tracks a & b.
REQ-034 Macro off: rerun REQ-030 without AND_GATE_STRUCT_STATS_EN -> hi_cnt = rise_cnt = sat = 0 throughout; y, y_q and y_rise are identical to the stats-enabled run.

Source files
------------

// File: rtl/and_gate_struct.sv
// Structural two-input AND with registered copy, rising-edge pulse and optional saturating statistics.
// Define AND_GATE_STRUCT_STATS_EN to build hi_cnt/rise_cnt/sat; otherwise they are tied to 0 and clr is ignored.
module and_gate_struct #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output wire              y,
  output logic             y_q,
  output logic             y_rise,
  output logic [CNT_W-1:0] hi_cnt,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             sat
);

  // Gate primitive keeps X/Z propagation and reset independence on the y path.
  and u_and (y, a, b);

  logic y_q_d;
  logic y_prev_q;
  logic y_prev_d;

  always_comb begin
    y_q_d    = y;
    y_prev_d = y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= 1'b0;
      y_prev_q <= 1'b0;
    end else begin
      y_q      <= y_q_d;
      y_prev_q <= y_prev_d;
    end
  end

  // High in the first cycle y_q is 1 after having been 0.
  assign y_rise = y_q & ~y_prev_q;

`ifdef AND_GATE_STRUCT_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] hi_cnt_q;
  logic [CNT_W-1:0] hi_cnt_d;
  logic [CNT_W-1:0] rise_cnt_q;
  logic [CNT_W-1:0] rise_cnt_d;
  logic             sat_q;
  logic             sat_d;

  always_comb begin
    hi_cnt_d   = hi_cnt_q;
    rise_cnt_d = rise_cnt_q;
    sat_d      = sat_q;
    if (clr) begin
      hi_cnt_d   = '0;
      rise_cnt_d = '0;
      sat_d      = 1'b0;
    end else begin
      if (y_q && (hi_cnt_q != CNT_MAX)) begin
        hi_cnt_d = hi_cnt_q + CNT_ONE;
      end
      if (y_rise && (rise_cnt_q != CNT_MAX)) begin
        rise_cnt_d = rise_cnt_q + CNT_ONE;
      end
      // Sticky: set once either counter sits at its ceiling.
      sat_d = sat_q | (hi_cnt_d == CNT_MAX) | (rise_cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt_q   <= '0;
      rise_cnt_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      hi_cnt_q   <= hi_cnt_d;
      rise_cnt_q <= rise_cnt_d;
      sat_q      <= sat_d;
    end
  end

  assign hi_cnt   = hi_cnt_q;
  assign rise_cnt = rise_cnt_q;
  assign sat      = sat_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign hi_cnt     = '0;
  assign rise_cnt   = '0;
  assign sat        = 1'b0;
`endif

endmodule

// File: tb/tb_and_gate_struct.sv
// Directed bench for and_gate_struct: one 8-bit-counter instance and one 2-bit-counter instance share stimulus.
module tb_and_gate_struct;

`ifdef AND_GATE_STRUCT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic clr;

  wire        y8;
  logic       y_q8;
  logic       y_rise8;
  logic [7:0] hi8;
  logic [7:0] rise8;
  logic       sat8;

  wire        y2;
  logic       y_q2;
  logic       y_rise2;
  logic [1:0] hi2;
  logic [1:0] rise2;
  logic       sat2;

  int checks = 0;
  int errors = 0;
  int pulses;

  and_gate_struct #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .y(y8), .y_q(y_q8), .y_rise(y_rise8),
    .hi_cnt(hi8), .rise_cnt(rise8), .sat(sat8)
  );

  and_gate_struct #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .y(y2), .y_q(y_q2), .y_rise(y_rise2),
    .hi_cnt(hi2), .rise_cnt(rise2), .sat(sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic av, input logic bv);
    @(negedge clk);
    rst_n = 1'b0;
    a = av;
    b = bv;
    clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a = 1'b0;
    b = 1'b0;
    clr = 1'b0;
    #2;
    chk("rst_y_q", y_q8, 0);
    chk("rst_y_rise", y_rise8, 0);
    chk("rst_hi", hi8, 0);
    chk("rst_rise", rise8, 0);
    chk("rst_sat", sat8, 0);

    // Truth table while held in reset: y is purely combinational.
    for (int i = 0; i < 4; i++) begin
      {a, b} = i[1:0];
      #1;
      chk($sformatf("tt_y_%0d", i), y8, (i == 3) ? 1 : 0);
      chk($sformatf("tt_y2_%0d", i), y2, (i == 3) ? 1 : 0);
      #9;
    end
    chk("tt_yq_in_reset", y_q8, 0);

    // Registered path: y_q follows y one edge later.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      {a, b} = i[1:0];
      step();
      chk($sformatf("tt_yq_%0d", i), y_q8, (i == 3) ? 1 : 0);
    end
    chk("tt_rise_after_11", y_rise8, 1);

    // Edge detect: a=b=1 loaded on E1..E5, b drops before E6.
    do_reset(1'b1, 1'b1);
    pulses = 0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 6) b = 1'b0;
      step();
      chk($sformatf("ed_yq_%0d", k), y_q8, (k <= 5) ? 1 : 0);
      chk($sformatf("ed_rise_%0d", k), y_rise8, (k == 1) ? 1 : 0);
      chk($sformatf("ed_rise2_%0d", k), y_rise2, (k == 1) ? 1 : 0);
      if (y_rise8 === 1'b1) pulses++;
    end
    chk("ed_pulses", pulses, 1);
    chk("ed_rise_cnt", rise8, STATS ? 1 : 0);
    chk("ed_hi_cnt", hi8, STATS ? 5 : 0);
    chk("ed_sat8", sat8, 0);
    chk("ed_hi2", hi2, STATS ? 3 : 0);
    chk("ed_sat2", sat2, STATS ? 1 : 0);

    // Clear priority, then saturation of the 2-bit instance.
    do_reset(1'b1, 1'b1);
    step(); step(); step();
    chk("clr_pre_hi2", hi2, STATS ? 2 : 0);
    chk("clr_pre_yq", y_q2, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_hi8", hi8, 0);
    chk("clr_hi2", hi2, 0);
    chk("clr_rise8", rise8, 0);
    chk("clr_sat2", sat2, 0);
    chk("clr_yq_kept", y_q8, 1);
    step();
    chk("clr_resume", hi8, STATS ? 1 : 0);
    step();
    chk("sat_pre", sat2, 0);
    step();
    chk("sat_hi2_max", hi2, STATS ? 3 : 0);
    chk("sat_set", sat2, STATS ? 1 : 0);
    step(); step();
    chk("sat_hi2_hold", hi2, STATS ? 3 : 0);
    chk("sat_hi8", hi8, STATS ? 5 : 0);
    a = 1'b0;
    step(); step();
    chk("sat_sticky", sat2, STATS ? 1 : 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("sat_cleared", sat2, 0);

    // Async reset mid-cycle with y_q=1 and hi_cnt=4.
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) step();
    chk("ar_pre_hi", hi8, STATS ? 4 : 0);
    chk("ar_pre_yq", y_q8, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_yq", y_q8, 0);
    chk("ar_y_rise", y_rise8, 0);
    chk("ar_hi", hi8, 0);
    chk("ar_sat2", sat2, 0);
    chk("ar_y_live", y8, 1);
    a = 1'b0;
    #1;
    chk("ar_y_track", y8, 0);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
